// File: rtl/lsf_event_sequencer.sv
// lsf_event_sequencer: frames each event as one ROI write, its hit writes, then an EOF pulse.
// Latency: ROI accept -> roi_we +1 cycle; hit accept -> mdt_hit_we +1 cycle; last write -> eof +1 cycle.
// Backpressure: downstream_af drops slc_ready/hit_ready only; writes already registered still complete.
//
// Ports:
//   clock, reset                      system clock, synchronous active-high reset
//   slc_in/slc_valid/slc_ready        candidate ROI handshake (accepted only in IDLE)
//   hit_in/hit_valid/hit_ready        hit beat handshake (accepted only in HITS)
//   hit_last, hit_null                beat qualifiers: final beat of event / no-data terminator
//   downstream_af                     almost-full from the LSF wrapper buffers
//   roi/roi_we, mdt_hit/mdt_hit_we    write ports toward the LSF wrapper (data held when strobe low)
//   eof                               one-cycle end-of-event pulse
//   histogram_accumulation_count      hits forwarded in the last completed event
//   err_overflow, err_timeout         sticky error flags, cleared only by reset
//   drop_cnt                          saturating count of hits dropped over the hit limit
module lsf_event_sequencer #(
  parameter int MAX_HITS      = 64,   // 1..1023
  parameter int TIMEOUT       = 512,  // >= 2
  parameter int GAP_CYCLES    = 4,    // >= 1
  parameter int HEG2SFSLC_LEN = 32,
  parameter int HEG2SFHIT_LEN = 24
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [HEG2SFSLC_LEN-1:0] slc_in,
  input  logic                     slc_valid,
  output logic                     slc_ready,
  input  logic [HEG2SFHIT_LEN-1:0] hit_in,
  input  logic                     hit_valid,
  input  logic                     hit_last,
  input  logic                     hit_null,
  output logic                     hit_ready,
  input  logic                     downstream_af,
  output logic [HEG2SFSLC_LEN-1:0] roi,
  output logic                     roi_we,
  output logic [HEG2SFHIT_LEN-1:0] mdt_hit,
  output logic                     mdt_hit_we,
  output logic                     eof,
  output logic [9:0]               histogram_accumulation_count,
  output logic                     err_overflow,
  output logic                     err_timeout,
  output logic [15:0]              drop_cnt
);

  localparam int               TMO_W     = $clog2(TIMEOUT) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam int               GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [9:0]       HIT_LIMIT = 10'(MAX_HITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROI,
    S_HITS,
    S_EOF,
    S_GAP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [9:0]       hit_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [TMO_W-1:0] tmo_nxt;
  logic [GAP_W-1:0] gap_cnt;

  logic slc_take;
  logic hit_take;
  logic last_take;
  logic hit_fwd;
  logic hit_drop;
  logic tmo_expire;

  // Ready lines are masked by reset so every output reads 0 while reset is held.
  assign slc_ready = (state == S_IDLE) & ~downstream_af & ~reset;
  assign hit_ready = (state == S_HITS) & ~downstream_af & ~reset;

  assign slc_take  = slc_valid & slc_ready;
  assign hit_take  = hit_valid & hit_ready;
  assign last_take = hit_take & hit_last;

  // Null beats only terminate; they are neither forwarded nor counted as drops.
  assign hit_fwd  = hit_take & ~hit_null & (hit_cnt < HIT_LIMIT);
  assign hit_drop = hit_take & ~hit_null & (hit_cnt >= HIT_LIMIT);

  // The forced EOF is taken on the edge where tmo_cnt reaches TIMEOUT-1. Counting
  // from the first HITS cycle, this puts the eof pulse exactly TIMEOUT cycles later,
  // the same one-cycle drain a normal hit_last termination gets.
  assign tmo_nxt    = tmo_cnt + TMO_W'(1);
  assign tmo_expire = (state == S_HITS) & (tmo_nxt == TMO_LAST);

  // ROI write is a pure function of state: the word was captured on the accept edge.
  assign roi_we = (state == S_ROI);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (slc_take) begin
          state_nxt = S_ROI;
        end
      end
      S_ROI: begin
        state_nxt = S_HITS;
      end
      S_HITS: begin
        if (last_take || tmo_expire) begin
          state_nxt = S_EOF;
        end
      end
      S_EOF: begin
        state_nxt = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state                        <= S_IDLE;
      roi                          <= '0;
      mdt_hit                      <= '0;
      mdt_hit_we                   <= 1'b0;
      eof                          <= 1'b0;
      histogram_accumulation_count <= '0;
      err_overflow                 <= 1'b0;
      err_timeout                  <= 1'b0;
      drop_cnt                     <= '0;
      hit_cnt                      <= '0;
      tmo_cnt                      <= '0;
      gap_cnt                      <= '0;
    end else begin
      state      <= state_nxt;
      mdt_hit_we <= hit_fwd;

      // EOF state is the cycle the final mdt_hit_we is visible; eof follows it.
      eof <= (state == S_EOF);

      if (slc_take) begin
        roi <= slc_in;
      end

      if (state == S_ROI) begin
        hit_cnt <= '0;
        tmo_cnt <= '0;
      end

      if (state == S_HITS) begin
        tmo_cnt <= tmo_nxt;
      end

      if (hit_fwd) begin
        mdt_hit <= hit_in;
        hit_cnt <= hit_cnt + 10'd1;
      end

      if (hit_drop) begin
        err_overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) begin
          drop_cnt <= drop_cnt + 16'd1;
        end
      end

      // A hit_last taken in the expiry cycle is a normal end, not a timeout.
      if (tmo_expire && !last_take) begin
        err_timeout <= 1'b1;
      end

      // hit_cnt is final by the EOF cycle, so the count lands together with eof.
      if (state == S_EOF) begin
        histogram_accumulation_count <= hit_cnt;
      end

      if (state == S_EOF) begin
        gap_cnt <= '0;
      end else if (state == S_GAP) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lsf_event_sequencer.sv
// tb_lsf_event_sequencer: directed stimulus against an event-level reference model.
// The model tracks events as windows of cycle numbers and scores every cycle.
// Hand-computed literals after each scenario pin the model's own timing.
module tb_lsf_event_sequencer;

  localparam int MAX_HITS   = 64;
  localparam int TIMEOUT    = 512;
  localparam int GAP_CYCLES = 4;
  localparam int SW         = 32;
  localparam int HW         = 24;

  logic          clock         = 1'b0;
  logic          reset         = 1'b1;
  logic [SW-1:0] slc_in        = '0;
  logic          slc_valid     = 1'b0;
  logic          slc_ready;
  logic [HW-1:0] hit_in        = '0;
  logic          hit_valid     = 1'b0;
  logic          hit_last      = 1'b0;
  logic          hit_null      = 1'b0;
  logic          hit_ready;
  logic          downstream_af = 1'b0;
  logic [SW-1:0] roi;
  logic          roi_we;
  logic [HW-1:0] mdt_hit;
  logic          mdt_hit_we;
  logic          eof;
  logic [9:0]    hist;
  logic          err_overflow;
  logic          err_timeout;
  logic [15:0]   drop_cnt;

  lsf_event_sequencer #(
    .MAX_HITS      (MAX_HITS),
    .TIMEOUT       (TIMEOUT),
    .GAP_CYCLES    (GAP_CYCLES),
    .HEG2SFSLC_LEN (SW),
    .HEG2SFHIT_LEN (HW)
  ) dut (
    .clock                        (clock),
    .reset                        (reset),
    .slc_in                       (slc_in),
    .slc_valid                    (slc_valid),
    .slc_ready                    (slc_ready),
    .hit_in                       (hit_in),
    .hit_valid                    (hit_valid),
    .hit_last                     (hit_last),
    .hit_null                     (hit_null),
    .hit_ready                    (hit_ready),
    .downstream_af                (downstream_af),
    .roi                          (roi),
    .roi_we                       (roi_we),
    .mdt_hit                      (mdt_hit),
    .mdt_hit_we                   (mdt_hit_we),
    .eof                          (eof),
    .histogram_accumulation_count (hist),
    .err_overflow                 (err_overflow),
    .err_timeout                  (err_timeout),
    .drop_cnt                     (drop_cnt)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle number, advanced on the active edge so negedge readers never race it.
  int cyc = 0;
  always @(posedge clock) cyc++;

  // Reference model state.
  bit            mdl_ok    = 1'b0;
  bit            ev_active = 1'b0;  // ROI accepted, event not yet terminated
  bit            fwd_due   = 1'b0;  // a forwarded hit must appear this cycle
  bit            m_ovf     = 1'b0;
  bit            m_tmo     = 1'b0;
  int            acc_cyc   = 0;     // cycle whose edge accepted the ROI
  int            eof_cyc   = -1000; // cycle the eof pulse is due
  int            m_cnt     = 0;
  int            m_hist    = 0;
  int            m_drop    = 0;
  logic [SW-1:0] m_roi     = '0;
  logic [HW-1:0] m_hit     = '0;

  // Observed DUT activity, read by the stimulus for the literal checks.
  int n_hit_we        = 0;
  int n_eof           = 0;
  int last_eof_cyc    = 0;
  int last_roi_we_cyc = 0;
  int hit_we_q[$];

  bit e_slc, e_hit, e_eof, hits_win, done;

  always @(negedge clock) begin
    // Event timeline: accept at a, roi_we at a+1, hits accepted from a+2 until the
    // terminating cycle t, eof at t+2, IDLE again GAP_CYCLES cycles after eof.
    hits_win = ev_active && (cyc >= acc_cyc + 2);
    e_hit    = mdl_ok && hits_win && !downstream_af && !reset;
    e_slc    = mdl_ok && !ev_active && (cyc >= eof_cyc + GAP_CYCLES) && !downstream_af && !reset;
    e_eof    = (cyc == eof_cyc);

    if (mdl_ok) begin
      if (e_eof) m_hist = m_cnt;
      chk("slc_ready",    slc_ready,    e_slc);
      chk("hit_ready",    hit_ready,    e_hit);
      chk("roi_we",       roi_we,       ev_active && (cyc == acc_cyc + 1));
      chk("roi",          roi,          m_roi);
      chk("mdt_hit_we",   mdt_hit_we,   fwd_due);
      chk("mdt_hit",      mdt_hit,      m_hit);
      chk("eof",          eof,          e_eof);
      chk("hist_count",   hist,         m_hist);
      chk("err_overflow", err_overflow, m_ovf);
      chk("err_timeout",  err_timeout,  m_tmo);
      chk("drop_cnt",     drop_cnt,     m_drop);
    end

    if (roi_we) last_roi_we_cyc = cyc;
    if (mdt_hit_we) begin
      n_hit_we++;
      hit_we_q.push_back(cyc);
    end
    if (eof) begin
      n_eof++;
      last_eof_cyc = cyc;
    end

    // Advance the model with what this cycle's edge will do.
    fwd_due = 1'b0;
    if (reset) begin
      mdl_ok    = 1'b1;
      ev_active = 1'b0;
      m_ovf     = 1'b0;
      m_tmo     = 1'b0;
      m_cnt     = 0;
      m_hist    = 0;
      m_drop    = 0;
      eof_cyc   = -1000;
      m_roi     = '0;
      m_hit     = '0;
    end else if (mdl_ok) begin
      if (slc_valid && e_slc) begin
        ev_active = 1'b1;
        acc_cyc   = cyc;
        m_roi     = slc_in;
        m_cnt     = 0;
      end
      if (hits_win) begin
        done = 1'b0;
        if (hit_valid && e_hit) begin
          if (!hit_null) begin
            if (m_cnt < MAX_HITS) begin
              fwd_due = 1'b1;
              m_hit   = hit_in;
              m_cnt++;
            end else begin
              m_ovf = 1'b1;
              if (m_drop < 65535) m_drop++;
            end
          end
          if (hit_last) done = 1'b1;
        end
        // Unterminated event: eof is due TIMEOUT cycles after the first HITS cycle.
        if (!done && (cyc - (acc_cyc + 2)) == TIMEOUT - 2) begin
          m_tmo = 1'b1;
          done  = 1'b1;
        end
        if (done) begin
          ev_active = 1'b0;
          eof_cyc   = cyc + 2;
        end
      end
    end
  end

  task automatic send_roi(input logic [SW-1:0] d, output int acc);
    int n;
    n         = 0;
    slc_in    = d;
    slc_valid = 1'b1;
    @(negedge clock);
    while (!slc_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    acc = cyc;
    if (!slc_ready) chk("roi_accept_wait", slc_ready, 1'b1);
    @(posedge clock);
    #1;
    slc_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [HW-1:0] d, input bit last, input bit nul);
    int n;
    n         = 0;
    hit_in    = d;
    hit_last  = last;
    hit_null  = nul;
    hit_valid = 1'b1;
    @(negedge clock);
    while (!hit_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!hit_ready) chk("hit_accept_wait", hit_ready, 1'b1);
    @(posedge clock);
    #1;
    hit_valid = 1'b0;
    hit_last  = 1'b0;
    hit_null  = 1'b0;
  endtask

  task automatic wait_eof(input int budget, input string nm);
    int n;
    n = 0;
    @(negedge clock);
    while (!eof && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (!eof) chk({nm, "_eof_wait"}, eof, 1'b1);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int s;
    int n;

    // Reset state, sampled while reset is still held.
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_roi_we",       roi_we,       1'b0);
    chk("rst_mdt_hit_we",   mdt_hit_we,   1'b0);
    chk("rst_eof",          eof,          1'b0);
    chk("rst_slc_ready",    slc_ready,    1'b0);
    chk("rst_hit_ready",    hit_ready,    1'b0);
    chk("rst_hist",         hist,         10'd0);
    chk("rst_err_overflow", err_overflow, 1'b0);
    chk("rst_err_timeout",  err_timeout,  1'b0);
    chk("rst_drop_cnt",     drop_cnt,     16'd0);
    chk("rst_roi",          roi,          '0);
    chk("rst_mdt_hit",      mdt_hit,      '0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // 1: ROI and three hits, last on the third.
    hit_we_q.delete();
    send_roi(32'hA1A1_0001, a);
    send_beat(24'h100001, 1'b0, 1'b0);
    send_beat(24'h100002, 1'b0, 1'b0);
    send_beat(24'h100003, 1'b1, 1'b0);
    wait_eof(50, "t1");
    chk("t1_roi_latency", last_roi_we_cyc - a, 1);
    chk("t1_hit_writes", hit_we_q.size(), 3);
    if (hit_we_q.size() == 3) begin
      chk("t1_hits_consecutive", hit_we_q[2] - hit_we_q[0], 2);
      chk("t1_eof_after_hits", last_eof_cyc - hit_we_q[2], 1);
    end
    chk("t1_count", hist, 10'd3);
    n = 0;
    while (!slc_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("t1_gap_cycles", n, GAP_CYCLES);
    @(posedge clock);
    #1;

    // 2: a lone null terminator beat.
    s = n_hit_we;
    send_roi(32'hB2B2_0002, a);
    send_beat(24'h0, 1'b1, 1'b1);
    wait_eof(50, "t2");
    chk("t2_hit_writes", n_hit_we - s, 0);
    chk("t2_count", hist, 10'd0);
    chk("t2_err_overflow", err_overflow, 1'b0);
    chk("t2_err_timeout", err_timeout, 1'b0);

    // 3: seventy hits against a limit of 64.
    s = n_hit_we;
    send_roi(32'hC3C3_0003, a);
    for (int i = 1; i <= 70; i++) begin
      send_beat(HW'(24'h300000 + i), (i == 70), 1'b0);
    end
    wait_eof(50, "t3");
    chk("t3_hit_writes", n_hit_we - s, 64);
    chk("t3_count", hist, 10'd64);
    chk("t3_err_overflow", err_overflow, 1'b1);
    chk("t3_drop_cnt", drop_cnt, 16'd6);

    // 4: five hits and no terminator; forced EOF.
    send_roi(32'hD4D4_0004, a);
    for (int i = 1; i <= 5; i++) begin
      send_beat(HW'(24'h400000 + i), 1'b0, 1'b0);
    end
    wait_eof(700, "t4");
    chk("t4_eof_latency", last_eof_cyc - (a + 2), TIMEOUT);
    chk("t4_count", hist, 10'd5);
    chk("t4_err_timeout", err_timeout, 1'b1);

    // 5: almost-full held for ten cycles mid-stream.
    s = n_hit_we;
    send_roi(32'hE5E5_0005, a);
    send_beat(24'h500001, 1'b0, 1'b0);
    send_beat(24'h500002, 1'b0, 1'b0);
    downstream_af = 1'b1;
    hit_in        = 24'h500003;
    hit_valid     = 1'b1;
    n = 0;
    repeat (10) begin
      @(negedge clock);
      if (hit_ready) n++;
    end
    @(posedge clock);
    #1;
    downstream_af = 1'b0;
    chk("t5_ready_during_af", n, 0);
    send_beat(24'h500003, 1'b0, 1'b0);
    send_beat(24'h500004, 1'b0, 1'b0);
    send_beat(24'h500005, 1'b0, 1'b0);
    send_beat(24'h500006, 1'b1, 1'b0);
    wait_eof(50, "t5");
    chk("t5_hit_writes", n_hit_we - s, 6);
    chk("t5_count", hist, 10'd6);

    // 6: reset in the middle of HITS after two hits.
    send_roi(32'hF6F6_0006, a);
    send_beat(24'h600001, 1'b0, 1'b0);
    send_beat(24'h600002, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("t6_roi_we",       roi_we,       1'b0);
    chk("t6_mdt_hit_we",   mdt_hit_we,   1'b0);
    chk("t6_eof",          eof,          1'b0);
    chk("t6_hit_ready",    hit_ready,    1'b0);
    chk("t6_hist",         hist,         10'd0);
    chk("t6_err_overflow", err_overflow, 1'b0);
    chk("t6_err_timeout",  err_timeout,  1'b0);
    chk("t6_drop_cnt",     drop_cnt,     16'd0);
    chk("t6_mdt_hit",      mdt_hit,      '0);
    #1;
    s = n_eof;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("t6_idle_ready", slc_ready, 1'b1);
    repeat (20) @(posedge clock);
    #1;
    chk("t6_no_eof", n_eof - s, 0);
    send_roi(32'h0707_0007, a);
    send_beat(24'h700001, 1'b1, 1'b0);
    wait_eof(50, "t6");
    chk("t6_count_after_reset", hist, 10'd1);
    repeat (8) @(posedge clock);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
